// File: rtl/frame_receiver.sv
// Frame sink after the Viterbi decoder: aligns to repeating {payload, zero tail}
// frames, recovers the payload and keeps saturating frame and bit-error counts.
module frame_receiver #(
  parameter int DATA_W = 4,
  parameter int TAIL_W = 3,
  parameter int LOCK_N = 2,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              sync_loss,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int FRAME_W = DATA_W + TAIL_W;
  localparam int POS_W   = $clog2(FRAME_W);
  localparam int FILL_W  = $clog2(FRAME_W + 1);
  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam int BAD_W   = $clog2(LOSS_N + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-2:0]  w_q, w_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DATA_W-1:0]   ref_q, ref_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dv_q, dv_d;
  logic                locked_q, locked_d;
  logic                sl_q, sl_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                s;
  logic [FRAME_W-1:0]  w_shift;
  logic [FILL_W-1:0]   fill_inc;
  logic                tail_ok;
  logic [DATA_W-1:0]   cand;
  logic                boundary;

  function automatic logic [CNT_W:0] popcount(input logic [DATA_W-1:0] v);
    logic [CNT_W:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + {{CNT_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == '1) ? a : a + CNT_W'(1);
  endfunction

  // Sum is formed one bit wider so overflow is visible before clamping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + b;
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // w_q keeps FRAME_W-1 past bits; with the incoming bit it forms the full window.
  assign s        = bit_en & din_valid;
  assign w_shift  = {w_q, din};
  assign fill_inc = (fill_q == FILL_W'(FRAME_W)) ? fill_q : fill_q + FILL_W'(1);
  assign tail_ok  = (w_shift[TAIL_W-1:0] == '0);
  assign cand     = w_shift[FRAME_W-1:TAIL_W];
  assign boundary = s && (pos_q == POS_W'(FRAME_W - 1));

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    fill_d      = fill_q;
    pos_d       = pos_q;
    ref_d       = ref_q;
    match_d     = match_q;
    bad_d       = bad_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    locked_d    = locked_q;
    sl_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (s) begin
      w_d    = w_shift[FRAME_W-2:0];
      fill_d = fill_inc;
      pos_d  = boundary ? '0 : pos_q + POS_W'(1);

      unique case (state_q)
        HUNT: begin
          // First zero-tail window after the buffer is full sets the frame phase.
          if (fill_inc == FILL_W'(FRAME_W) && tail_ok) begin
            ref_d   = cand;
            pos_d   = '0;
            match_d = MATCH_W'(1);
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (tail_ok && cand == ref_q) begin
              if (match_q + MATCH_W'(1) == MATCH_W'(LOCK_N)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                data_d   = ref_q;
                dv_d     = 1'b1;
                bad_d    = '0;
              end else begin
                match_d = match_q + MATCH_W'(1);
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            frame_cnt_d = sat_inc(frame_cnt_q);
            err_cnt_d   = sat_add(err_cnt_q, popcount(cand ^ data_q));
            data_d      = cand;
            dv_d        = 1'b1;
            if (!tail_ok) begin
              if (bad_q + BAD_W'(1) == BAD_W'(LOSS_N)) begin
                state_d  = HUNT;
                locked_d = 1'b0;
                sl_d     = 1'b1;
                bad_d    = '0;
              end else begin
                bad_d = bad_q + BAD_W'(1);
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      w_q         <= '0;
      fill_q      <= '0;
      pos_q       <= '0;
      ref_q       <= '0;
      match_q     <= '0;
      bad_q       <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      locked_q    <= 1'b0;
      sl_q        <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      fill_q      <= fill_d;
      pos_q       <= pos_d;
      ref_q       <= ref_d;
      match_q     <= match_d;
      bad_q       <= bad_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      locked_q    <= locked_d;
      sl_q        <= sl_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign locked     = locked_q;
  assign sync_loss  = sl_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: directed scenarios plus randomized frames, checked
// each cycle against a bit-history reference model; a 4-bit-counter copy covers saturation.
module tb_frame_receiver;

  localparam int FRAME_W = 7;
  localparam int LOCK_N  = 2;
  localparam int LOSS_N  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;

  logic [3:0]  data_out, data_out4;
  logic        data_valid, data_valid4, locked, locked4, sync_loss, sync_loss4;
  logic [15:0] frame_cnt, err_cnt;
  logic [3:0]  frame_cnt4, err_cnt4;

  frame_receiver #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .din_valid(din_valid),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .sync_loss(sync_loss), .frame_cnt(frame_cnt), .err_cnt(err_cnt));

  frame_receiver #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .din(din), .din_valid(din_valid),
    .data_out(data_out4), .data_valid(data_valid4), .locked(locked4),
    .sync_loss(sync_loss4), .frame_cnt(frame_cnt4), .err_cnt(err_cnt4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_seen  = 0;
  int sl_seen  = 0;

  // Reference model state: mode 0 = hunting, 1 = verifying, 2 = locked.
  bit         hist[$];
  int         mode, since_b, ok_frames, bad_frames, frames, errs;
  logic [3:0] ref_pl, exp_data;
  bit         exp_dv, exp_sl, exp_lock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_tick(input bit r, input bit en, input bit d, input bit v);
    logic [3:0] pl;
    logic [2:0] tl;
    exp_dv = 1'b0;
    exp_sl = 1'b0;
    if (r) begin
      hist.delete();
      mode = 0; since_b = 0; ok_frames = 0; bad_frames = 0;
      frames = 0; errs = 0; exp_data = '0; exp_lock = 1'b0;
      return;
    end
    if (!(en && v)) return;
    hist.push_back(d);
    if (hist.size() > FRAME_W) void'(hist.pop_front());
    if (hist.size() < FRAME_W) return;
    for (int i = 0; i < 4; i++) pl[3-i] = hist[i];
    for (int i = 0; i < 3; i++) tl[2-i] = hist[4+i];
    if (mode == 0) begin
      if (tl == 0) begin
        ref_pl = pl; ok_frames = 1; since_b = 0; mode = 1;
      end
      return;
    end
    since_b++;
    if (since_b < FRAME_W) return;
    since_b = 0;
    if (mode == 1) begin
      if (tl == 0 && pl == ref_pl) begin
        ok_frames++;
        if (ok_frames == LOCK_N) begin
          mode = 2; exp_lock = 1'b1; exp_data = ref_pl; exp_dv = 1'b1; bad_frames = 0;
        end
      end else begin
        mode = 0;
      end
    end else begin
      frames++;
      errs += $countones(pl ^ exp_data);
      exp_data = pl;
      exp_dv = 1'b1;
      bad_frames = (tl != 0) ? bad_frames + 1 : 0;
      if (bad_frames == LOSS_N) begin
        mode = 0; exp_lock = 1'b0; exp_sl = 1'b1; bad_frames = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit d, input bit v);
    @(negedge clk);
    rst = r; bit_en = en; din = d; din_valid = v;
    model_tick(r, en, d, v);
    @(posedge clk);
    #1;
    check_eq("data_out",   32'(data_out),   32'(exp_data));
    check_eq("data_valid", 32'(data_valid), 32'(exp_dv));
    check_eq("locked",     32'(locked),     32'(exp_lock));
    check_eq("sync_loss",  32'(sync_loss),  32'(exp_sl));
    check_eq("frame_cnt",  32'(frame_cnt),  32'(clamp(frames, 65535)));
    check_eq("err_cnt",    32'(err_cnt),    32'(clamp(errs, 65535)));
    check_eq("frame_cnt4", 32'(frame_cnt4), 32'(clamp(frames, 15)));
    check_eq("err_cnt4",   32'(err_cnt4),   32'(clamp(errs, 15)));
    if (data_valid) dv_seen++;
    if (sync_loss) sl_seen++;
  endtask

  task automatic send_bit(input bit d, input int gap);
    drive(1'b0, 1'b1, d, 1'b1);
    repeat (gap) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(input logic [6:0] f, input int gap);
    for (int i = 6; i >= 0; i--) send_bit(f[i], gap);
  endtask

  initial begin
    model_tick(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);

    // Clean 1011 stream, one sample every 4 clocks
    dv_seen = 0;
    repeat (6) send_frame(7'b1011000, 3);
    check_eq("p1_locked", 32'(locked), 32'd1);
    check_eq("p1_data", 32'(data_out), 32'hB);
    check_eq("p1_err", 32'(err_cnt), 32'd0);
    check_eq("p1_dv_count", 32'(dv_seen), 32'd5);

    // Single payload bit flip, then restored
    send_frame(7'b1111000, 3);
    check_eq("p2_err1", 32'(err_cnt), 32'd1);
    send_frame(7'b1011000, 3);
    check_eq("p2_err2", 32'(err_cnt), 32'd2);
    check_eq("p2_locked", 32'(locked), 32'd1);

    // Two bad tails drop lock, clean stream relocks
    sl_seen = 0;
    send_frame(7'b1011001, 1);
    check_eq("p3_still_locked", 32'(locked), 32'd1);
    send_frame(7'b1011001, 1);
    check_eq("p3_sync_loss", 32'(sl_seen), 32'd1);
    check_eq("p3_unlocked", 32'(locked), 32'd0);
    repeat (3) send_frame(7'b1011000, 1);
    check_eq("p3_relocked", 32'(locked), 32'd1);

    // Bits with din_valid low are ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) begin
      drive(1'b0, 1'b1, 1'($urandom), 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    repeat (4) send_frame(7'b0101000, 1);
    check_eq("p4_locked", 32'(locked), 32'd1);
    check_eq("p4_data", 32'(data_out), 32'h5);

    // Back-to-back samples until nine frames, then reset mid-frame
    for (int k = 0; k < 20 && frames < 9; k++) send_frame(7'b0101000, 0);
    check_eq("p5_frames", 32'(frame_cnt), 32'd9);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("p5_rst_locked", 32'(locked), 32'd0);
    check_eq("p5_rst_frames", 32'(frame_cnt), 32'd0);
    check_eq("p5_rst_data", 32'(data_out), 32'd0);
    check_eq("p5_rst_err", 32'(err_cnt), 32'd0);

    // Full payload flips every frame: 4-bit counter must clamp at 15
    repeat (2) send_frame(7'b1011000, 1);
    repeat (3) begin
      send_frame(7'b0100000, 1);
      send_frame(7'b1011000, 1);
    end
    check_eq("p6_err4_sat", 32'(err_cnt4), 32'hF);
    check_eq("p6_err16", 32'(err_cnt), 32'd24);

    // Randomized frames: payload changes, tail corruption, gaps, drops, resets
    begin
      logic [3:0] pl;
      logic [2:0] tl;
      pl = 4'($urandom);
      for (int f = 0; f < 400; f++) begin
        if ($urandom_range(0, 3) == 0) pl = 4'($urandom);
        tl = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
        if ($urandom_range(0, 299) == 0) drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
          logic [6:0] fr;
          fr = {pl, tl};
          if ($urandom_range(0, 40) == 0) drive(1'b0, 1'b1, 1'($urandom), 1'b0);
          send_bit(fr[i], $urandom_range(0, 3));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
